// File: rtl/run_monitor_pkg.sv
// Shared types and default parameters for the run monitor.
// The FSM state enum and parameter defaults live here.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_MAX_CYCLES = 1000;

endpackage

// File: rtl/run_monitor_if.sv
// Processor-side capture inputs and monitor status bundle.
// master drives start/out_valid/out_data/halt/rd_en; slave is the monitor.
interface run_monitor_if
  import run_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                       start;
  logic                       out_valid;
  logic signed [DATA_W-1:0]   out_data;
  logic                       halt;
  logic                       rd_en;
  logic signed [DATA_W-1:0]   rd_data;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic                       overflow;
  logic [CNT_W-1:0]           cycles;
  logic [DATA_W-1:0]          checksum;

  modport master (
    output start, out_valid, out_data, halt, rd_en,
    input  rd_data, empty, count, busy, done, timeout, overflow, cycles, checksum
  );

  modport slave (
    input  start, out_valid, out_data, halt, rd_en,
    output rd_data, empty, count, busy, done, timeout, overflow, cycles, checksum
  );
endinterface

// File: rtl/mon_fifo.sv
// Capture FIFO: write visible on rdata/count one cycle after push; rdata is 0 when empty.
// Push into a full FIFO is accepted only alongside a pop; otherwise the caller sees it dropped.
module mon_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: IDLE/RUN/DONE FSM, RUN-cycle watchdog and capture FIFO; status updates one cycle after inputs.
// Captures while full without a pop are dropped (sticky overflow); checksum accumulator built only with RUN_MONITOR_CHECKSUM_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input logic          clk,
  input logic          rst,
  run_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cycles_q;
  logic             timeout_q;
  logic             overflow_q;
  logic             enter_run;
  logic             timeout_set;
  logic             run;
  logic             cap;
  logic             drop;
  logic             fifo_full;

  assign run  = (state == RUN);
  assign cap  = run && bus.out_valid;
  // A same-cycle pop always frees a slot on a full FIFO, so only a pop-less capture is lost.
  assign drop = cap && fifo_full && !bus.rd_en;

  always_comb begin
    state_nxt   = state;
    enter_run   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          state_nxt = DONE;
        end else if (cycles_q == WD_LAST) begin
          state_nxt   = DONE;
          timeout_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_run) begin
        cycles_q   <= '0;
        timeout_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (run)         cycles_q   <= cycles_q + 1'b1;
        if (timeout_set) timeout_q  <= 1'b1;
        if (drop)        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.busy     = run;
  assign bus.done     = (state == DONE);
  assign bus.timeout  = timeout_q;
  assign bus.overflow = overflow_q;
  assign bus.cycles   = cycles_q;

`ifdef RUN_MONITOR_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (enter_run) begin
      sum_q <= '0;
    end else if (cap && !drop) begin
      sum_q <= sum_q + bus.out_data;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

  mon_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (enter_run),
    .push  (cap),
    .pop   (bus.rd_en),
    .wdata (bus.out_data),
    .rdata (bus.rd_data),
    .count (bus.count),
    .full  (fifo_full),
    .empty (bus.empty)
  );

endmodule
